pipe_stall_ctrl: RTL

//  Pipeline sequencer for the 5-stage ARM core. Drives freeze/flush of PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB regs.

---
 rtl/arm_pipe_pkg.sv | 13 +
 rtl/hazard_detect.sv | 39 +++
 rtl/pipe_stall_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline sequencer.
package arm_pipe_pkg;

  localparam int REG_IDX_W = 4;
  // r15 reads the PC, so it can never be a data-hazard source.
  localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW / load-use detector for the instruction sitting in ID.
// With forwarding on, only a load in EXE can stall (its data is not yet
// available to forward). With forwarding off, any pending write in EXE or
// MEM to a register that ID reads forces a bubble.
module hazard_detect
  import arm_pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src1_id,
  input  logic [REG_IDX_W-1:0] src2_id,
  input  logic                 two_src_id,
  input  logic [REG_IDX_W-1:0] dest_exe,
  input  logic                 wb_enb_exe,
  input  logic                 mem_read_exe,
  input  logic [REG_IDX_W-1:0] dest_mem,
  input  logic                 wb_enb_mem,
  input  logic                 fwd_en,
  output logic                 hazard
);

  logic match_exe;
  logic match_mem;

  // An ID operand matches a destination unless that destination is the PC.
  assign match_exe = (dest_exe != PC_IDX) &&
                     ((src1_id == dest_exe) || (two_src_id && (src2_id == dest_exe)));
  assign match_mem = (dest_mem != PC_IDX) &&
                     ((src1_id == dest_mem) || (two_src_id && (src2_id == dest_mem)));

  // Select the hazard rule according to whether forwarding is available.
  always_comb begin
    hazard = 1'b0;
    if (fwd_en) begin
      hazard = mem_read_exe & wb_enb_exe & match_exe;
    end else begin
      hazard = (wb_enb_exe & match_exe) | (wb_enb_mem & match_mem);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: sole source of freeze/flush for the five pipeline
// registers. SRAM wait states freeze everything; otherwise a taken branch
// flushes IF/ID and ID/EXE, and a data hazard holds PC/IF/ID and inserts
// a bubble into ID/EXE. Control outputs are combinational so they act in
// the same cycle; only the FSM, wait counter, timeout flag and counters
// are flopped.
// Build option: define PIPE_PERF_CNT_EN for live saturating performance
// counters; otherwise the counter ports read zero and no counter flops exist.
module pipe_stall_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] src1_id,
  input  logic [REG_IDX_W-1:0] src2_id,
  input  logic                 two_src_id,
  input  logic [REG_IDX_W-1:0] dest_exe,
  input  logic                 wb_enb_exe,
  input  logic                 mem_read_exe,
  input  logic [REG_IDX_W-1:0] dest_mem,
  input  logic                 wb_enb_mem,
  input  logic                 fwd_en,
  input  logic                 B_exe,
  input  logic                 mem_req,
  input  logic                 sram_ready,
  output logic                 pc_freeze,
  output logic                 ifid_freeze,
  output logic                 ifid_flush,
  output logic                 idex_freeze,
  output logic                 idex_flush,
  output logic                 exmem_freeze,
  output logic                 memwb_freeze,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events,
  output logic [CNT_W-1:0]     wait_cycles
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  pipe_state_t       state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              hazard;
  logic              in_wait;
  logic              mem_stall;
  logic              timeout_hit;
  logic              branch_act;
  logic              hazard_act;

  hazard_detect u_hazard_detect (
    .src1_id      (src1_id),
    .src2_id      (src2_id),
    .two_src_id   (two_src_id),
    .dest_exe     (dest_exe),
    .wb_enb_exe   (wb_enb_exe),
    .mem_read_exe (mem_read_exe),
    .dest_mem     (dest_mem),
    .wb_enb_mem   (wb_enb_mem),
    .fwd_en       (fwd_en),
    .hazard       (hazard)
  );

  assign in_wait     = (state_q == S_MEM_WAIT);
  // While waiting, mem_req is not re-sampled: the frozen MEM stage still owns the access.
  assign mem_stall   = in_wait ? ~sram_ready : (mem_req & ~sram_ready);
  assign timeout_hit = in_wait & (wait_cnt_q == WCNT_LAST);
  // Branch beats hazard: the ID instruction is being flushed anyway.
  assign branch_act  = ~mem_stall & B_exe;
  assign hazard_act  = ~mem_stall & ~B_exe & hazard;

  // Next-state for the SRAM wait FSM, its cycle counter and the sticky timeout.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q | timeout_hit;
    case (state_q)
      S_RUN: begin
        wait_cnt_d = '0;
        if (mem_req & ~sram_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (sram_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WCNT_LAST) begin
          // Hold at the last value; the sticky flag remembers the timeout.
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Same-cycle freeze/flush decode; everything forced low while in reset.
  always_comb begin
    pc_freeze    = 1'b0;
    ifid_freeze  = 1'b0;
    ifid_flush   = 1'b0;
    idex_freeze  = 1'b0;
    idex_flush   = 1'b0;
    exmem_freeze = 1'b0;
    memwb_freeze = 1'b0;
    mem_timeout  = 1'b0;
    if (rst_n) begin
      mem_timeout = mem_timeout_q | timeout_hit;
      if (mem_stall) begin
        pc_freeze    = 1'b1;
        ifid_freeze  = 1'b1;
        idex_freeze  = 1'b1;
        exmem_freeze = 1'b1;
        memwb_freeze = 1'b1;
      end else if (branch_act) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (hazard_act) begin
        pc_freeze   = 1'b1;
        ifid_freeze = 1'b1;
        idex_flush  = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] wait_cyc_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cyc_q  <= '0;
    end else begin
      stall_cnt_q <= sat_inc(stall_cnt_q, hazard_act);
      flush_cnt_q <= sat_inc(flush_cnt_q, branch_act);
      wait_cyc_q  <= sat_inc(wait_cyc_q, in_wait);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
  assign wait_cycles  = wait_cyc_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
  assign wait_cycles  = '0;
`endif

endmodule
